// File: rtl/qam_pkg.sv
// Shared 64-QAM definitions used by the SPI receiver and the data_clk symbol mapper.
// Optional build macro: SPI_PARITY_EN adds the RX_PARITY state.
package qam_pkg;

  localparam int unsigned SYM_BITS = 6;

  typedef logic [SYM_BITS-1:0] sym_t;

`ifdef SPI_PARITY_EN
  typedef enum logic [1:0] {
    RX_IDLE   = 2'd0,
    RX_SHIFT  = 2'd1,
    RX_PARITY = 2'd2
  } rx_state_t;
`else
  typedef enum logic [1:0] {
    RX_IDLE   = 2'd0,
    RX_SHIFT  = 2'd1
  } rx_state_t;
`endif

endpackage

// File: rtl/spi_symbol_receiver_if.sv
// Two-phase toggle req/ack symbol channel from the SCLK domain to the data_clk domain.
interface spi_symbol_receiver_if;
  import qam_pkg::*;

  sym_t sym_data;
  logic req_tgl;
  logic ack_tgl;

  modport master (output sym_data, output req_tgl, input ack_tgl);
  modport slave  (input sym_data, input req_tgl, output ack_tgl);
endinterface

// File: rtl/toggle_sync.sv
// Generic multi-flop synchroniser for a toggle signal crossing clock domains.
module toggle_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  // Shift the async input through the flop chain; bit 0 is the first stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= STAGES'({r_sync, i_d});
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/spi_symbol_receiver.sv
// SPI slave front end: deserialises MOSI into QAM symbols, buffers them in a FIFO
// and offers them to the data_clk domain over a toggle req/ack handshake.
// Optional build macro: SPI_PARITY_EN (even parity bit after each symbol, parity_err port).
module spi_symbol_receiver
  import qam_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                          SCLK,
  input  logic                          rst_n,
  input  logic                          cs_n,
  input  logic                          mosi,
  spi_symbol_receiver_if.master         hs,
  output logic                          overrun,
  output logic                          frame_err,
`ifdef SPI_PARITY_EN
  output logic                          parity_err,
`endif
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam int unsigned CNT_W = $clog2(SYM_BITS + 1);

  rx_state_t        r_state;
  sym_t             r_shift;
  logic [CNT_W-1:0] r_bit_cnt;
  logic             r_frame_err;
  logic             r_overrun;
`ifdef SPI_PARITY_EN
  logic             r_parity_err;
`endif

  sym_t             r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;

  sym_t             r_sym_data;
  logic             r_req_tgl;

  logic             w_ack_s;
  sym_t             w_sym_next;
  sym_t             w_wr_data;
  logic             w_wr;
  logic             w_last_bit;
  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic             w_push;

  // Bring the data_clk acknowledge toggle into the SCLK domain.
  toggle_sync #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .clk   (SCLK),
    .rst_n (rst_n),
    .i_d   (hs.ack_tgl),
    .o_q   (w_ack_s)
  );

  // Decode a completed symbol from the current state and incoming bit.
  always_comb begin
    w_sym_next = {r_shift[SYM_BITS-2:0], mosi};
    w_last_bit = (r_bit_cnt == CNT_W'(SYM_BITS - 1));
    w_wr       = 1'b0;
    w_wr_data  = w_sym_next;
    case (r_state)
`ifdef SPI_PARITY_EN
      RX_PARITY: begin
        w_wr_data = r_shift;
        w_wr      = !cs_n && ((^r_shift) == mosi);
      end
`else
      RX_SHIFT: begin
        w_wr = !cs_n && w_last_bit;
      end
`endif
      default: begin
        w_wr = 1'b0;
      end
    endcase
  end

  assign w_full  = (r_level == LVL_W'(FIFO_DEPTH));
  assign w_empty = (r_level == '0);
  assign w_pop   = (w_ack_s == r_req_tgl) && !w_empty;
  // A pop on the same edge frees the slot, so a full FIFO can still accept.
  assign w_push  = w_wr && (!w_full || w_pop);

  // RX FSM: bit counting, shift register and framing/parity flags.
  always_ff @(posedge SCLK or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= RX_IDLE;
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_frame_err <= 1'b0;
`ifdef SPI_PARITY_EN
      r_parity_err <= 1'b0;
`endif
    end else begin
      case (r_state)
        RX_IDLE: begin
          if (!cs_n) begin
            r_shift   <= {{(SYM_BITS-1){1'b0}}, mosi};
            r_bit_cnt <= CNT_W'(1);
            r_state   <= RX_SHIFT;
          end
        end
        RX_SHIFT: begin
          if (cs_n) begin
            r_state   <= RX_IDLE;
            r_bit_cnt <= '0;
            if (r_bit_cnt != '0) begin
              r_frame_err <= 1'b1;
            end
          end else begin
            r_shift <= w_sym_next;
            if (w_last_bit) begin
              r_bit_cnt <= '0;
`ifdef SPI_PARITY_EN
              r_state   <= RX_PARITY;
`endif
            end else begin
              r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            end
          end
        end
`ifdef SPI_PARITY_EN
        RX_PARITY: begin
          r_bit_cnt <= '0;
          if (cs_n) begin
            r_state     <= RX_IDLE;
            r_frame_err <= 1'b1;
          end else begin
            r_state <= RX_SHIFT;
            if ((^r_shift) != mosi) begin
              r_parity_err <= 1'b1;
            end
          end
        end
`endif
        default: begin
          r_state   <= RX_IDLE;
          r_bit_cnt <= '0;
        end
      endcase
    end
  end

  // FIFO storage; contents need no reset because level gates every read.
  always_ff @(posedge SCLK) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_wr_data;
    end
  end

  // FIFO pointers, occupancy and overrun detection.
  always_ff @(posedge SCLK or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_level   <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_level <= r_level + LVL_W'(1);
      end else if (w_pop && !w_push) begin
        r_level <= r_level - LVL_W'(1);
      end
      if (w_wr && !w_push) begin
        r_overrun <= 1'b1;
      end
    end
  end

  // Present the FIFO head and raise a new request whenever the channel is idle.
  always_ff @(posedge SCLK or negedge rst_n) begin
    if (!rst_n) begin
      r_sym_data <= '0;
      r_req_tgl  <= 1'b0;
    end else if (w_pop) begin
      r_sym_data <= r_mem[r_rd_ptr];
      r_req_tgl  <= ~r_req_tgl;
    end
  end

  assign hs.sym_data = r_sym_data;
  assign hs.req_tgl  = r_req_tgl;
  assign overrun     = r_overrun;
  assign frame_err   = r_frame_err;
  assign fifo_level  = r_level;
`ifdef SPI_PARITY_EN
  assign parity_err  = r_parity_err;
`endif

endmodule

// File: tb/tb_spi_symbol_receiver.sv
// Self-checking bench for spi_symbol_receiver: table-driven bursts plus a
// scoreboard that matches every req_tgl toggle against the expected symbol order.
module tb_spi_symbol_receiver;
  import qam_pkg::*;

  logic       SCLK = 1'b0;
  logic       rst_n;
  logic       cs_n;
  logic       mosi;
  logic       overrun;
  logic       frame_err;
  logic [2:0] fifo_level;
`ifdef SPI_PARITY_EN
  logic       parity_err;
`endif

  spi_symbol_receiver_if hs_if ();

  spi_symbol_receiver #(.FIFO_DEPTH(4), .SYNC_STAGES(2)) dut (
    .SCLK       (SCLK),
    .rst_n      (rst_n),
    .cs_n       (cs_n),
    .mosi       (mosi),
    .hs         (hs_if),
    .overrun    (overrun),
    .frame_err  (frame_err),
`ifdef SPI_PARITY_EN
    .parity_err (parity_err),
`endif
    .fifo_level (fifo_level)
  );

  always #5 SCLK = ~SCLK;

  typedef struct {
    sym_t       data;
    logic [2:0] lvl;
    logic       ovr;
  } vec_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  sym_t exp_q[$];
  logic mon_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: each new request must carry the next expected symbol.
  always @(negedge SCLK) begin : monitor
    sym_t e;
    if (!rst_n) begin
      mon_prev = 1'b0;
    end else if (hs_if.req_tgl !== mon_prev) begin
      mon_prev = hs_if.req_tgl;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_req: got sym 0x%0h expected no request", hs_if.sym_data);
      end else begin
        e = exp_q.pop_front();
        check("scoreboard_sym", 32'(hs_if.sym_data), 32'(e));
      end
    end
  end

  task automatic send_bits(input logic [7:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      cs_n = 1'b0;
      mosi = v[i];
      @(negedge SCLK);
    end
  endtask

  task automatic send_sym(input sym_t s);
`ifdef SPI_PARITY_EN
    send_bits({1'b0, s, ^s}, 7);
`else
    send_bits(8'(s), 6);
`endif
  endtask

  task automatic cs_high();
    cs_n = 1'b1;
    mosi = 1'b0;
    @(negedge SCLK);
  endtask

  task automatic ack_toggle();
    hs_if.ack_tgl = ~hs_if.ack_tgl;
    repeat (3) @(negedge SCLK);
  endtask

  vec_t burst [4];
  vec_t ovf   [6];

  initial begin
    burst[0] = '{6'h3F, 3'd1, 1'b0};
    burst[1] = '{6'h00, 3'd1, 1'b0};
    burst[2] = '{6'h15, 3'd2, 1'b0};
    burst[3] = '{6'h2A, 3'd3, 1'b0};
    ovf[0]   = '{6'h01, 3'd1, 1'b0};
    ovf[1]   = '{6'h02, 3'd1, 1'b0};
    ovf[2]   = '{6'h03, 3'd2, 1'b0};
    ovf[3]   = '{6'h04, 3'd3, 1'b0};
    ovf[4]   = '{6'h05, 3'd4, 1'b0};
    ovf[5]   = '{6'h06, 3'd4, 1'b1};

    rst_n = 1'b0;
    cs_n  = 1'b1;
    mosi  = 1'b0;
    hs_if.ack_tgl = 1'b0;
    repeat (2) @(negedge SCLK);
    check("rst_sym_data", 32'(hs_if.sym_data), 32'h0);
    check("rst_req_tgl", 32'(hs_if.req_tgl), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);
    check("rst_frame_err", 32'(frame_err), 32'h0);
    check("rst_fifo_level", 32'(fifo_level), 32'h0);
    #2 rst_n = 1'b1;
    @(negedge SCLK);

    // Single symbol: request one edge after the last bit, then no retoggle.
    exp_q.push_back(6'b101101);
    send_sym(6'b101101);
    check("single_req_at_N", 32'(hs_if.req_tgl), 32'h0);
    check("single_level_at_N", 32'(fifo_level), 32'h1);
    cs_high();
    check("single_req_at_N1", 32'(hs_if.req_tgl), 32'h1);
    check("single_sym_at_N1", 32'(hs_if.sym_data), 32'h2D);
    repeat (3) @(negedge SCLK);
    check("single_req_held", 32'(hs_if.req_tgl), 32'h1);
    check("single_frame_err", 32'(frame_err), 32'h0);
    ack_toggle();
    check("single_no_retoggle", 32'(hs_if.req_tgl), 32'(hs_if.ack_tgl));

    // Burst of four with ack held.
    foreach (burst[i]) exp_q.push_back(burst[i].data);
    for (int i = 0; i < 4; i++) begin
      send_sym(burst[i].data);
      check("burst_level", 32'(fifo_level), 32'(burst[i].lvl));
    end
    cs_high();
    check("burst_head", 32'(hs_if.sym_data), 32'h3F);
    check("burst_level_held", 32'(fifo_level), 32'h3);
    for (int i = 1; i < 4; i++) begin
      hs_if.ack_tgl = ~hs_if.ack_tgl;
      @(negedge SCLK);
      check("burst_sym_stable", 32'(hs_if.sym_data), 32'(burst[i-1].data));
      repeat (2) @(negedge SCLK);
      check("burst_sym_next", 32'(hs_if.sym_data), 32'(burst[i].data));
      check("burst_level_drain", 32'(fifo_level), 32'(3 - i));
    end
    ack_toggle();
    check("burst_idle", 32'(hs_if.req_tgl), 32'(hs_if.ack_tgl));
    check("burst_overrun", 32'(overrun), 32'h0);

    // Overflow: six symbols with ack frozen; the sixth is dropped.
    for (int i = 0; i < 5; i++) exp_q.push_back(ovf[i].data);
    for (int i = 0; i < 6; i++) begin
      send_sym(ovf[i].data);
      check("ovf_level", 32'(fifo_level), 32'(ovf[i].lvl));
      check("ovf_flag", 32'(overrun), 32'(ovf[i].ovr));
    end
    cs_high();
    check("ovf_head", 32'(hs_if.sym_data), 32'h01);
    for (int i = 1; i < 5; i++) begin
      ack_toggle();
      check("ovf_sym", 32'(hs_if.sym_data), 32'(ovf[i].data));
      check("ovf_level_drain", 32'(fifo_level), 32'(4 - i));
    end
    ack_toggle();
    check("ovf_idle", 32'(hs_if.req_tgl), 32'(hs_if.ack_tgl));
    check("ovf_sticky", 32'(overrun), 32'h1);

    // Framing: partial symbol then a good one.
    send_bits(8'b110, 3);
    cs_high();
    check("frame_err_set", 32'(frame_err), 32'h1);
    check("frame_level", 32'(fifo_level), 32'h0);
    exp_q.push_back(6'h07);
    send_sym(6'h07);
    cs_high();
    check("frame_next_sym", 32'(hs_if.sym_data), 32'h07);
    ack_toggle();

    // Reset with a request outstanding and two symbols queued.
    exp_q.push_back(6'h21);
    send_sym(6'h21);
    send_sym(6'h22);
    send_sym(6'h23);
    cs_high();
    check("prerst_level", 32'(fifo_level), 32'h2);
    #2 rst_n = 1'b0;
    hs_if.ack_tgl = 1'b0;
    #1;
    check("mrst_sym_data", 32'(hs_if.sym_data), 32'h0);
    check("mrst_req_tgl", 32'(hs_if.req_tgl), 32'h0);
    check("mrst_overrun", 32'(overrun), 32'h0);
    check("mrst_frame_err", 32'(frame_err), 32'h0);
    check("mrst_level", 32'(fifo_level), 32'h0);
    exp_q.delete();
    @(negedge SCLK);
    #2 rst_n = 1'b1;
    @(negedge SCLK);
    exp_q.push_back(6'h11);
    send_sym(6'h11);
    cs_high();
    check("postrst_req", 32'(hs_if.req_tgl), 32'h1);
    check("postrst_sym", 32'(hs_if.sym_data), 32'h11);
    check("postrst_frame_err", 32'(frame_err), 32'h0);
    ack_toggle();

`ifdef SPI_PARITY_EN
    // Bad parity drops the symbol; good parity delivers it.
    send_bits({1'b0, 6'b000011, 1'b1}, 7);
    cs_high();
    check("par_err_set", 32'(parity_err), 32'h1);
    check("par_level", 32'(fifo_level), 32'h0);
    exp_q.push_back(6'h03);
    send_bits({1'b0, 6'b000011, 1'b0}, 7);
    cs_high();
    check("par_good_sym", 32'(hs_if.sym_data), 32'h03);
    check("par_frame_err", 32'(frame_err), 32'h0);
    ack_toggle();
`endif

    repeat (5) @(negedge SCLK);
    check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
